// File: rtl/mult_booth.sv
// mult_booth: sequential signed 32x32 multiplier, radix-2 Booth, one step per clock.
// The 64-bit product lands in HI/LO; multBusy stalls the control unit and
// multDone pulses for one cycle when HI/LO take a new result.
//
// state | meaning
// IDLE  | waiting for MultCtrl; operands loaded on the start edge
// RUN   | 32 Booth steps, one per edge
// DONE  | HI/LO written, multDone raised, back to IDLE
module mult_booth (
  input  logic        clk,
  input  logic        reset,
  input  logic        MultCtrl,
  input  logic [31:0] multiplicando,
  input  logic [31:0] multiplicador,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        multBusy,
  output logic        multDone
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  // 33-bit accumulator and multiplicand so that M = -2^31 negates without overflow
  logic [32:0] acc;
  logic [32:0] m_ext;
  logic [31:0] q;
  logic        qm1;
  logic [5:0]  count;
  logic [32:0] acc_sum;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; MultCtrl only matters in IDLE, so no queuing or restart
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (MultCtrl) state_nxt = RUN;
      RUN:  if (count == 6'd31) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Booth recode of {Q[0],Qm1}: add, subtract or pass the accumulator
  always_comb begin
    acc_sum = acc;
    case ({q[0], qm1})
      2'b01:   acc_sum = acc + m_ext;
      2'b10:   acc_sum = acc - m_ext;
      default: acc_sum = acc;
    endcase
  end

  assign multBusy = (state == RUN) || (state == DONE);

  // Datapath: load on start, shift {A,Q,Qm1} right arithmetically each step, publish in DONE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc      <= '0;
      m_ext    <= '0;
      q        <= '0;
      qm1      <= 1'b0;
      count    <= '0;
      HI       <= '0;
      LO       <= '0;
      multDone <= 1'b0;
    end else begin
      multDone <= 1'b0;
      case (state)
        IDLE: begin
          if (MultCtrl) begin
            acc   <= '0;
            q     <= multiplicador;
            qm1   <= 1'b0;
            m_ext <= {multiplicando[31], multiplicando};
            count <= '0;
          end
        end
        RUN: begin
          acc   <= {acc_sum[32], acc_sum[32:1]};
          q     <= {acc_sum[0], q[31:1]};
          qm1   <= q[0];
          count <= count + 6'd1;
        end
        DONE: begin
          // acc[32] only guards the -2^31 case; the product fits in acc[31:0]:Q
          HI       <= acc[31:0];
          LO       <= q;
          multDone <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_booth.sv
// tb_mult_booth: directed vectors for mult_booth with hand-computed products.
module tb_mult_booth;

  logic        clk;
  logic        reset;
  logic        MultCtrl;
  logic [31:0] multiplicando;
  logic [31:0] multiplicador;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        multBusy;
  logic        multDone;

  int checks;
  int failures;

  mult_booth dut (
    .clk           (clk),
    .reset         (reset),
    .MultCtrl      (MultCtrl),
    .multiplicando (multiplicando),
    .multiplicador (multiplicador),
    .HI            (HI),
    .LO            (LO),
    .multBusy      (multBusy),
    .multDone      (multDone)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One multiply from start edge E to E+34. With disturb set, operands are
  // corrupted during RUN and MultCtrl is pulsed again at E+10.
  task automatic do_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] expected, input bit disturb);
    logic        busy_ok;
    logic        done_early;
    logic        hold_ok;
    logic [31:0] hi_prev;
    logic [31:0] lo_prev;
    @(negedge clk);
    MultCtrl      = 1'b1;
    multiplicando = a;
    multiplicador = b;
    hi_prev       = HI;
    lo_prev       = LO;
    @(posedge clk);
    #1;
    check({tag, "_busy_after_start"}, {63'd0, multBusy}, 64'd1);
    busy_ok    = 1'b1;
    done_early = 1'b0;
    hold_ok    = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      MultCtrl = disturb && (i == 10);
      if (disturb && i == 1) begin
        multiplicando = 32'hDEADBEEF;
        multiplicador = 32'hDEADBEEF;
      end
      @(posedge clk);
      #1;
      if (!multBusy) busy_ok = 1'b0;
      if (multDone) done_early = 1'b1;
      if (HI !== hi_prev || LO !== lo_prev) hold_ok = 1'b0;
    end
    check({tag, "_busy_run"}, {63'd0, busy_ok}, 64'd1);
    check({tag, "_no_early_done"}, {63'd0, done_early}, 64'd0);
    check({tag, "_hilo_hold_run"}, {63'd0, hold_ok}, 64'd1);
    @(negedge clk);
    MultCtrl = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_done_e33"}, {63'd0, multDone}, 64'd1);
    check({tag, "_busy_e33"}, {63'd0, multBusy}, 64'd0);
    check({tag, "_product"}, {HI, LO}, expected);
    @(posedge clk);
    #1;
    check({tag, "_done_e34"}, {63'd0, multDone}, 64'd0);
    check({tag, "_idle_e34"}, {63'd0, multBusy}, 64'd0);
  endtask

  initial begin
    logic done_seen;
    checks        = 0;
    failures      = 0;
    reset         = 1'b0;
    MultCtrl      = 1'b0;
    multiplicando = '0;
    multiplicador = '0;

    #1;
    check("reset_hilo", {HI, LO}, 64'd0);
    check("reset_busy", {63'd0, multBusy}, 64'd0);
    check("reset_done", {63'd0, multDone}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    do_mult("basic_3x5",  32'd3,          32'd5,          64'h0000_0000_0000_000F, 1'b0);
    do_mult("neg7x6",     32'hFFFF_FFF9,  32'd6,          64'hFFFF_FFFF_FFFF_FFD6, 1'b0);
    do_mult("6xneg7",     32'd6,          32'hFFFF_FFF9,  64'hFFFF_FFFF_FFFF_FFD6, 1'b0);
    do_mult("min_x_min",  32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000, 1'b0);
    do_mult("max_x_max",  32'h7FFF_FFFF,  32'h7FFF_FFFF,  64'h3FFF_FFFF_0000_0001, 1'b0);
    do_mult("m1_x_m1",    32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h0000_0000_0000_0001, 1'b0);
    do_mult("zero",       32'd0,          32'h1234_5678,  64'd0,                   1'b0);
    do_mult("stable",     32'd100,        32'd200,        64'h0000_0000_0000_4E20, 1'b1);

    // Reset mid-RUN: HI/LO currently 0x4E20, start 12345 x 678 and abort at E+10
    @(negedge clk);
    MultCtrl      = 1'b1;
    multiplicando = 32'd12345;
    multiplicador = 32'd678;
    @(posedge clk);
    @(negedge clk);
    MultCtrl = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid_hilo", {HI, LO}, 64'd0);
    check("rst_mid_busy", {63'd0, multBusy}, 64'd0);
    check("rst_mid_done", {63'd0, multDone}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset     = 1'b1;
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (multDone || multBusy) done_seen = 1'b1;
    end
    check("rst_aborted", {63'd0, done_seen}, 64'd0);
    // 12345 * 678 = 8369910 = 0x7FB6F6
    do_mult("restart", 32'd12345, 32'd678, 64'd8369910, 1'b0);

    // Back-to-back with MultCtrl held high: 2x3, 4x5, 6x7, 34-cycle period
    @(negedge clk);
    MultCtrl      = 1'b1;
    multiplicando = 32'd2;
    multiplicador = 32'd3;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) begin
        multiplicando = 32'd4;
        multiplicador = 32'd5;
      end else if (k == 1) begin
        multiplicando = 32'd6;
        multiplicador = 32'd7;
      end else begin
        MultCtrl = 1'b0;
      end
      repeat (32) @(posedge clk);
      #1;
      check($sformatf("b2b%0d_done_e32", k), {63'd0, multDone}, 64'd0);
      @(posedge clk);
      #1;
      check($sformatf("b2b%0d_done_e33", k), {63'd0, multDone}, 64'd1);
      check($sformatf("b2b%0d_product", k), {HI, LO},
            (k == 0) ? 64'd6 : (k == 1) ? 64'd20 : 64'd42);
      @(posedge clk);
      #1;
      check($sformatf("b2b%0d_done_e34", k), {63'd0, multDone}, 64'd0);
      check($sformatf("b2b%0d_busy_e34", k), {63'd0, multBusy}, (k < 2) ? 64'd1 : 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
